// File: rtl/reg_wb.sv
// reg_wb -- register write-back unit for the cpu15 core.
//
// Owns the eight general registers read by the decode stage. A write
// (register number + data) is accepted over a valid/ready handshake into a
// one-entry pending slot. It is committed on a following edge unless STALL is
// high. Same-edge commit and accept is supported, so the unit can sustain one
// write per cycle.
//
// Ports:
//   CLK_WB      in   write-back clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   WB_VALID    in   write request present
//   WB_READY    out  request can be accepted this cycle
//   N_REG_IN    in   destination register number
//   WB_DATA     in   write data
//   STALL       in   blocks commit of the pending write
//   REG0..REG7  out  registered register contents
//   BUSY        out  one-hot of the pending destination, 0 when slot empty
//   WB_DONE     out  one-cycle pulse after a commit edge
//   N_REG_OUT   out  register number of the last committed write
//
// Optional build macro:
//   REG_WB_ZERO_REG_EN  REG0 reads as constant zero. Writes to register 0
//                       still handshake and report completion, but never
//                       modify it.

module reg_wb #(
   parameter int unsigned          DATA_W    = 16,
   parameter logic [DATA_W-1:0]    RESET_VAL = 16'h0000
) (
   input  logic              CLK_WB,
   input  logic              RST_N,
   input  logic              WB_VALID,
   output logic              WB_READY,
   input  logic [2:0]        N_REG_IN,
   input  logic [DATA_W-1:0] WB_DATA,
   input  logic              STALL,
   output logic [DATA_W-1:0] REG0,
   output logic [DATA_W-1:0] REG1,
   output logic [DATA_W-1:0] REG2,
   output logic [DATA_W-1:0] REG3,
   output logic [DATA_W-1:0] REG4,
   output logic [DATA_W-1:0] REG5,
   output logic [DATA_W-1:0] REG6,
   output logic [DATA_W-1:0] REG7,
   output logic [7:0]        BUSY,
   output logic              WB_DONE,
   output logic [2:0]        N_REG_OUT
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        pend_n;
   logic [DATA_W-1:0] pend_data;
   logic [DATA_W-1:0] regs [8];
   logic              accept;
   logic              commit;

   always_ff @(posedge CLK_WB or negedge RST_N) begin
      if (!RST_N) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      WB_READY  = 1'b0;
      accept    = 1'b0;
      commit    = 1'b0;
      BUSY      = '0;
      state_nxt = state;

      // A stalled full slot cannot drain, so it cannot take a new request.
      WB_READY = (state == EMPTY) || !STALL;
      accept   = WB_VALID && WB_READY;
      commit   = (state == FULL) && !STALL;

      if (state == FULL) begin
         BUSY[pend_n] = 1'b1;
      end

      if (accept) begin
         state_nxt = FULL;
      end else if (commit) begin
         state_nxt = EMPTY;
      end
   end

   // Pending slot: refilled on every accept, including the edge that commits
   // its previous contents.
   always_ff @(posedge CLK_WB or negedge RST_N) begin
      if (!RST_N) begin
         pend_n    <= '0;
         pend_data <= '0;
      end else if (accept) begin
         pend_n    <= N_REG_IN;
         pend_data <= WB_DATA;
      end
   end

   always_ff @(posedge CLK_WB or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < 8; i++) begin
            regs[i] <= RESET_VAL;
         end
      end else begin
`ifdef REG_WB_ZERO_REG_EN
         if (commit && (pend_n != 3'd0)) begin
            regs[pend_n] <= pend_data;
         end
`else
         if (commit) begin
            regs[pend_n] <= pend_data;
         end
`endif
      end
   end

   always_ff @(posedge CLK_WB or negedge RST_N) begin
      if (!RST_N) begin
         WB_DONE   <= 1'b0;
         N_REG_OUT <= '0;
      end else begin
         WB_DONE <= commit;
         if (commit) begin
            N_REG_OUT <= pend_n;
         end
      end
   end

`ifdef REG_WB_ZERO_REG_EN
   assign REG0 = '0;
`else
   assign REG0 = regs[0];
`endif
   assign REG1 = regs[1];
   assign REG2 = regs[2];
   assign REG3 = regs[3];
   assign REG4 = regs[4];
   assign REG5 = regs[5];
   assign REG6 = regs[6];
   assign REG7 = regs[7];

endmodule

// File: tb/tb_reg_wb.sv
module tb_reg_wb;

   logic        CLK_WB;
   logic        RST_N;
   logic        WB_VALID;
   logic        WB_READY;
   logic [2:0]  N_REG_IN;
   logic [15:0] WB_DATA;
   logic        STALL;
   logic [15:0] regv [8];
   logic [7:0]  BUSY;
   logic        WB_DONE;
   logic [2:0]  N_REG_OUT;

   int checks = 0;
   int errors = 0;

   logic [15:0] vals [8];
   logic [15:0] exp_r0;

   reg_wb #(.DATA_W(16), .RESET_VAL(16'h0000)) dut (
      .CLK_WB    (CLK_WB),
      .RST_N     (RST_N),
      .WB_VALID  (WB_VALID),
      .WB_READY  (WB_READY),
      .N_REG_IN  (N_REG_IN),
      .WB_DATA   (WB_DATA),
      .STALL     (STALL),
      .REG0      (regv[0]),
      .REG1      (regv[1]),
      .REG2      (regv[2]),
      .REG3      (regv[3]),
      .REG4      (regv[4]),
      .REG5      (regv[5]),
      .REG6      (regv[6]),
      .REG7      (regv[7]),
      .BUSY      (BUSY),
      .WB_DONE   (WB_DONE),
      .N_REG_OUT (N_REG_OUT)
   );

   initial CLK_WB = 1'b0;
   always #5 CLK_WB = ~CLK_WB;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      vals[0] = 16'h6535; vals[1] = 16'h7628; vals[2] = 16'h7e6e; vals[3] = 16'habcd;
      vals[4] = 16'h64a6; vals[5] = 16'h0000; vals[6] = 16'h34b1; vals[7] = 16'h808d;
`ifdef REG_WB_ZERO_REG_EN
      exp_r0 = 16'h0000;
`else
      exp_r0 = 16'h6535;
`endif

      // Reset, no traffic
      RST_N = 1'b0; WB_VALID = 1'b0; N_REG_IN = '0; WB_DATA = '0; STALL = 1'b0;
      repeat (3) @(posedge CLK_WB);
      @(negedge CLK_WB);
      RST_N = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) chk($sformatf("rst_reg%0d", i), regv[i], 16'h0000);
      chk("rst_busy", BUSY, 8'h00);
      chk("rst_done", WB_DONE, 1'b0);
      chk("rst_ready", WB_READY, 1'b1);
      chk("rst_nout", N_REG_OUT, 3'b000);

      // Single write REG3 = abcd
      @(negedge CLK_WB);
      WB_VALID = 1'b1; N_REG_IN = 3'd3; WB_DATA = 16'habcd;
      @(posedge CLK_WB);
      @(negedge CLK_WB);
      WB_VALID = 1'b0;
      #1;
      chk("single_busy", BUSY, 8'h08);
      chk("single_reg3_pre", regv[3], 16'h0000);
      chk("single_done_pre", WB_DONE, 1'b0);
      @(negedge CLK_WB);
      chk("single_reg3", regv[3], 16'habcd);
      chk("single_done", WB_DONE, 1'b1);
      chk("single_nout", N_REG_OUT, 3'b011);
      chk("single_busy_clr", BUSY, 8'h00);
      @(negedge CLK_WB);
      chk("single_done_clr", WB_DONE, 1'b0);

      // Eight back-to-back writes; done for write i-2 is visible while write i is presented
      for (int i = 0; i < 8; i++) begin
         WB_VALID = 1'b1; N_REG_IN = 3'(i); WB_DATA = vals[i];
         #1;
         chk($sformatf("b2b_ready%0d", i), WB_READY, 1'b1);
         if (i >= 2) begin
            chk($sformatf("b2b_done%0d", i - 2), WB_DONE, 1'b1);
            chk($sformatf("b2b_nout%0d", i - 2), N_REG_OUT, 32'(i - 2));
         end
         @(negedge CLK_WB);
      end
      WB_VALID = 1'b0;
      #1;
      chk("b2b_done6", WB_DONE, 1'b1);
      chk("b2b_nout6", N_REG_OUT, 3'd6);
      @(negedge CLK_WB);
      chk("b2b_done7", WB_DONE, 1'b1);
      chk("b2b_nout7", N_REG_OUT, 3'd7);
      @(negedge CLK_WB);
      chk("b2b_done_clr", WB_DONE, 1'b0);
      chk("b2b_reg0", regv[0], exp_r0);
      for (int i = 1; i < 8; i++) chk($sformatf("b2b_reg%0d", i), regv[i], vals[i]);

      // Stalled write REG5 = 1111; request during stall must be ignored
      WB_VALID = 1'b1; N_REG_IN = 3'd5; WB_DATA = 16'h1111;
      @(negedge CLK_WB);
      STALL = 1'b1;
      for (int c = 0; c < 4; c++) begin
         WB_VALID = 1'b1; N_REG_IN = 3'd1; WB_DATA = 16'hdead;
         #1;
         chk($sformatf("stall_ready%0d", c), WB_READY, 1'b0);
         chk($sformatf("stall_busy%0d", c), BUSY, 8'h20);
         chk($sformatf("stall_reg5_%0d", c), regv[5], 16'h0000);
         chk($sformatf("stall_done%0d", c), WB_DONE, 1'b0);
         @(negedge CLK_WB);
      end
      WB_VALID = 1'b0; STALL = 1'b0;
      #1;
      chk("unstall_ready", WB_READY, 1'b1);
      @(negedge CLK_WB);
      chk("unstall_reg5", regv[5], 16'h1111);
      chk("unstall_done", WB_DONE, 1'b1);
      chk("unstall_nout", N_REG_OUT, 3'd5);
      chk("unstall_busy", BUSY, 8'h00);
      chk("unstall_reg1", regv[1], 16'h7628);
      @(negedge CLK_WB);
      chk("unstall_done_clr", WB_DONE, 1'b0);

      // Two writes to REG2: last one wins
      WB_VALID = 1'b1; N_REG_IN = 3'd2; WB_DATA = 16'h0001;
      @(negedge CLK_WB);
      WB_DATA = 16'h0002;
      @(negedge CLK_WB);
      WB_VALID = 1'b0;
      #1;
      chk("same_done1", WB_DONE, 1'b1);
      chk("same_nout1", N_REG_OUT, 3'b010);
      chk("same_reg2_1", regv[2], 16'h0001);
      @(negedge CLK_WB);
      chk("same_done2", WB_DONE, 1'b1);
      chk("same_nout2", N_REG_OUT, 3'b010);
      chk("same_reg2_2", regv[2], 16'h0002);
      @(negedge CLK_WB);
      chk("same_done_clr", WB_DONE, 1'b0);

      // Reset before commit: pending write discarded, async clear mid-cycle
      WB_VALID = 1'b1; N_REG_IN = 3'd6; WB_DATA = 16'hffff;
      @(negedge CLK_WB);
      WB_VALID = 1'b0;
      #1;
      chk("rstmid_busy_pre", BUSY, 8'h40);
      #1;
      RST_N = 1'b0;
      #1;
      chk("rstmid_reg6", regv[6], 16'h0000);
      chk("rstmid_reg3", regv[3], 16'h0000);
      chk("rstmid_busy", BUSY, 8'h00);
      chk("rstmid_done", WB_DONE, 1'b0);
      chk("rstmid_nout", N_REG_OUT, 3'b000);
      @(negedge CLK_WB);
      RST_N = 1'b1;
      #1;
      chk("rstrel_ready", WB_READY, 1'b1);
      @(negedge CLK_WB);
      chk("rstrel_reg6", regv[6], 16'h0000);
      chk("rstrel_done", WB_DONE, 1'b0);
      chk("rstrel_busy", BUSY, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
